keypad_digit_entry: RTL and testbench

- Sits directly downstream of the keypad priority encoder and consumes its digit code `D` and its `all_off` flag.
- Debounces key press and release, and accepts exactly one digit per physical press.
- Shifts accepted digits into a 4-digit BCD MM:SS entry buffer for the microwave time-setting logic.
- Issues a one-cycle strobe per accepted digit.

---
 rtl/keypad_digit_entry.sv | 166 ++++++++++++++++
 tb/tb_keypad_digit_entry.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_entry.sv
// Debounced keypad digit capture into a 4-digit BCD MM:SS entry buffer.
// Optional: define LEADING_ZERO_SKIP_EN to discard a 0 entered as the first digit.
module keypad_digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DB_WIDTH        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enablen,
    input  logic [3:0]  D,
    input  logic        all_off,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic [2:0]  entry_count,
    output logic        entry_full,
    output logic        digit_valid,
    output logic [3:0]  digit_out,
    output logic        key_held
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT
    } state_t;

    localparam logic [DB_WIDTH-1:0] DB_LAST    = DB_WIDTH'(DEBOUNCE_CYCLES);
    localparam bit                  SINGLE_CYC = (DEBOUNCE_CYCLES == 1);

    state_t              state;
    logic [DB_WIDTH-1:0] cnt;
    logic [DB_WIDTH-1:0] cnt_inc;
    logic [3:0]          cand;
    logic                accept;
    logic                skip;
    logic                shift;

    assign cnt_inc = cnt + DB_WIDTH'(1);

    // The accepted digit always equals the live D: in PRESS_WAIT acceptance
    // requires D == cand, and the single-cycle case accepts straight from IDLE.
    always_comb begin
        accept = 1'b0;
        if (!enablen && !clear && !all_off) begin
            if (state == IDLE)
                accept = SINGLE_CYC;
            else if (state == PRESS_WAIT)
                accept = (D == cand) && (cnt_inc == DB_LAST);
        end
    end

`ifdef LEADING_ZERO_SKIP_EN
    assign skip = (D == 4'd0) && (entry_count == 3'd0);
`else
    assign skip = 1'b0;
`endif

    assign shift = accept && !entry_full && !skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            key_held <= 1'b0;
        end else if (enablen) begin
            state    <= IDLE;
            cnt      <= '0;
            key_held <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            if (!all_off) begin
                state    <= PRESSED;
                key_held <= 1'b1;
            end else begin
                state    <= IDLE;
                key_held <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!all_off) begin
                        cand <= D;
                        if (SINGLE_CYC) begin
                            state    <= PRESSED;
                            cnt      <= '0;
                            key_held <= 1'b1;
                        end else begin
                            state <= PRESS_WAIT;
                            cnt   <= DB_WIDTH'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (all_off) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (D != cand) begin
                        cand <= D;
                        cnt  <= DB_WIDTH'(1);
                    end else if (cnt_inc == DB_LAST) begin
                        state    <= PRESSED;
                        cnt      <= '0;
                        key_held <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESSED: begin
                    if (all_off) begin
                        if (SINGLE_CYC) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            key_held <= 1'b0;
                        end else begin
                            state <= REL_WAIT;
                            cnt   <= DB_WIDTH'(1);
                        end
                    end
                end
                REL_WAIT: begin
                    if (!all_off) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt_inc == DB_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        key_held <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_bcd    <= '0;
            entry_count <= '0;
            entry_full  <= 1'b0;
            digit_valid <= 1'b0;
            digit_out   <= '0;
        end else begin
            digit_valid <= 1'b0;
            if (clear) begin
                time_bcd    <= '0;
                entry_count <= '0;
                entry_full  <= 1'b0;
            end else if (shift) begin
                time_bcd    <= {time_bcd[11:0], D};
                entry_count <= entry_count + 3'd1;
                entry_full  <= (entry_count == 3'd3);
                digit_out   <= D;
                digit_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed self-checking bench for keypad_digit_entry (DEBOUNCE_CYCLES=4).
module tb_keypad_digit_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        enablen;
    logic [3:0]  D;
    logic        all_off;
    logic        clear;
    logic [15:0] time_bcd;
    logic [2:0]  entry_count;
    logic        entry_full;
    logic        digit_valid;
    logic [3:0]  digit_out;
    logic        key_held;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pulses = 0;
    logic        prev_valid = 1'b0;
    logic        double_pulse = 1'b0;
    int unsigned base;

    keypad_digit_entry #(
        .DEBOUNCE_CYCLES(4),
        .DB_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enablen(enablen),
        .D(D),
        .all_off(all_off),
        .clear(clear),
        .time_bcd(time_bcd),
        .entry_count(entry_count),
        .entry_full(entry_full),
        .digit_valid(digit_valid),
        .digit_out(digit_out),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Pulses completed before each rising edge; also flags back-to-back pulses.
    always @(posedge clk) begin
        if (digit_valid) pulses++;
        if (digit_valid && prev_valid) double_pulse = 1'b1;
        prev_valid = digit_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d, input int unsigned hold, input int unsigned rel);
        D = d;
        all_off = 1'b0;
        step(hold);
        all_off = 1'b1;
        step(rel);
    endtask

    initial begin
        rst = 1'b1; enablen = 1'b0; D = 4'd0; all_off = 1'b1; clear = 1'b0;
        #2;
        check("rst_time", time_bcd, 16'h0000);
        check("rst_count", entry_count, 3'd0);
        check("rst_valid", digit_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        step(2);
        rst = 1'b0;
        step(2);

        // Single press of 5: pulse on the 4th edge of stable press.
        D = 4'd5; all_off = 1'b0;
        step(3);
        check("p5_early", digit_valid, 1'b0);
        step(1);
        check("p5_valid", digit_valid, 1'b1);
        check("p5_digit", digit_out, 4'd5);
        check("p5_time", time_bcd, 16'h0005);
        check("p5_count", entry_count, 3'd1);
        check("p5_held", key_held, 1'b1);
        step(1);
        check("p5_one_cycle", digit_valid, 1'b0);
        step(5);
        all_off = 1'b1;
        step(3);
        check("rel_wait_held", key_held, 1'b1);
        step(1);
        check("rel_done", key_held, 1'b0);
        step(6);
        check("p5_pulses", pulses, 32'd1);

        // Bounce then stable hold of 3.
        base = pulses;
        D = 4'd3;
        for (int i = 0; i < 3; i++) begin
            all_off = 1'b0; step(2);
            all_off = 1'b1; step(2);
        end
        check("bounce_nopulse", pulses, base);
        all_off = 1'b0;
        step(3);
        check("bounce_early", digit_valid, 1'b0);
        step(1);
        check("bounce_valid", digit_valid, 1'b1);
        check("bounce_digit", digit_out, 4'd3);
        check("bounce_time", time_bcd, 16'h0053);
        step(6);
        all_off = 1'b1;
        step(10);
        check("bounce_pulses", pulses, base + 1);

        // Fill the buffer, then a 5th digit is ignored.
        clear = 1'b1; step(1); clear = 1'b0;
        check("clr_time", time_bcd, 16'h0000);
        check("clr_count", entry_count, 3'd0);
        base = pulses;
        press(4'd1, 6, 6);
        press(4'd2, 6, 6);
        press(4'd3, 6, 6);
        press(4'd0, 6, 6);
        check("fill_time", time_bcd, 16'h1230);
        check("fill_full", entry_full, 1'b1);
        check("fill_count", entry_count, 3'd4);
        check("fill_pulses", pulses, base + 4);
        D = 4'd7; all_off = 1'b0;
        step(6);
        check("full_held", key_held, 1'b1);
        all_off = 1'b1;
        step(6);
        check("full_time", time_bcd, 16'h1230);
        check("full_pulses", pulses, base + 4);

        // Clear mid-hold: held key is not re-entered.
        clear = 1'b1; step(1); clear = 1'b0;
        D = 4'd8; all_off = 1'b0;
        step(6);
        check("hold8_time", time_bcd, 16'h0008);
        clear = 1'b1; step(1); clear = 1'b0;
        check("hold_clr_time", time_bcd, 16'h0000);
        check("hold_clr_count", entry_count, 3'd0);
        check("hold_clr_held", key_held, 1'b1);
        base = pulses;
        step(8);
        check("hold_clr_nopulse", pulses, base);
        all_off = 1'b1;
        step(6);
        press(4'd8, 6, 6);
        check("repress8_time", time_bcd, 16'h0008);
        check("repress8_pulses", pulses, base + 1);

        // Clear coinciding with the accept edge wins.
        clear = 1'b1; step(1); clear = 1'b0;
        base = pulses;
        D = 4'd4; all_off = 1'b0;
        step(3);
        clear = 1'b1; step(1); clear = 1'b0;
        check("clr_acc_valid", digit_valid, 1'b0);
        check("clr_acc_time", time_bcd, 16'h0000);
        step(6);
        all_off = 1'b1;
        step(6);
        check("clr_acc_pulses", pulses, base);

        // Async reset while in PRESS_WAIT with 0042 entered.
        press(4'd4, 6, 6);
        press(4'd2, 6, 6);
        check("pre_rst_time", time_bcd, 16'h0042);
        D = 4'd6; all_off = 1'b0;
        step(2);
        #2 rst = 1'b1;
        #1;
        check("arst_time", time_bcd, 16'h0000);
        check("arst_count", entry_count, 3'd0);
        check("arst_full", entry_full, 1'b0);
        check("arst_digit", digit_out, 4'd0);
        check("arst_held", key_held, 1'b0);
        all_off = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);

        // Disabled: presses are ignored.
        base = pulses;
        enablen = 1'b1;
        D = 4'd9; all_off = 1'b0;
        step(8);
        check("dis_held", key_held, 1'b0);
        all_off = 1'b1;
        step(2);
        check("dis_pulses", pulses, base);
        check("dis_time", time_bcd, 16'h0000);
        enablen = 1'b0;
        step(2);

        // Leading zeros.
        base = pulses;
        press(4'd0, 6, 6);
        press(4'd0, 6, 6);
        press(4'd9, 6, 6);
        check("lz_time", time_bcd, 16'h0009);
`ifdef LEADING_ZERO_SKIP_EN
        check("lz_count", entry_count, 3'd1);
        check("lz_pulses", pulses, base + 1);
`else
        check("lz_count", entry_count, 3'd3);
        check("lz_pulses", pulses, base + 3);
`endif
        check("no_double_pulse", double_pulse, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
